// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings, state/class enums and decode helpers for the FP execute unit
package fpu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_PIPE, S_WAIT_ITER, S_DONE} state_e;

    typedef enum logic [1:0] {CLS_SIMPLE, CLS_PIPE, CLS_ITER, CLS_BAD} op_class_e;

    typedef enum logic [3:0] {
        COP_ADD    = 4'd0,
        COP_SUB    = 4'd1,
        COP_MUL    = 4'd2,
        COP_FMADD  = 4'd3,
        COP_FMSUB  = 4'd4,
        COP_FNMSUB = 4'd5,
        COP_FNMADD = 4'd6,
        COP_CVT    = 4'd7,
        COP_DIV    = 4'd8,
        COP_SQRT   = 4'd9,
        COP_NONE   = 4'd15
    } core_op_e;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [4:0] F5_ADD     = 5'b00000;
    localparam logic [4:0] F5_SUB     = 5'b00001;
    localparam logic [4:0] F5_MUL     = 5'b00010;
    localparam logic [4:0] F5_DIV     = 5'b00011;
    localparam logic [4:0] F5_SGNJ    = 5'b00100;
    localparam logic [4:0] F5_MINMAX  = 5'b00101;
    localparam logic [4:0] F5_SQRT    = 5'b01011;
    localparam logic [4:0] F5_CVT_S_W = 5'b11010;
    localparam logic [4:0] F5_MV_W_X  = 5'b11110;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Which execution path an instruction takes; unknown encodings retire without a write
    function automatic op_class_e op_class(input logic [6:0] opc, input logic [4:0] f5, input logic [2:0] f3);
        if (opc == OPC_FMADD || opc == OPC_FMSUB || opc == OPC_FNMSUB || opc == OPC_FNMADD)
            return CLS_PIPE;
        if (opc != OPC_OP_FP)
            return CLS_BAD;
        case (f5)
            F5_SGNJ:                           return f3 <= 3'd2 ? CLS_SIMPLE : CLS_BAD;
            F5_MINMAX:                         return f3 <= 3'd1 ? CLS_SIMPLE : CLS_BAD;
            F5_MV_W_X:                         return CLS_SIMPLE;
            F5_ADD, F5_SUB, F5_MUL, F5_CVT_S_W: return CLS_PIPE;
            F5_DIV, F5_SQRT:                   return CLS_ITER;
            default:                           return CLS_BAD;
        endcase
    endfunction

    // Operation code handed to the arithmetic cores
    function automatic core_op_e core_op_of(input logic [6:0] opc, input logic [4:0] f5);
        case (opc)
            OPC_FMADD:  return COP_FMADD;
            OPC_FMSUB:  return COP_FMSUB;
            OPC_FNMSUB: return COP_FNMSUB;
            OPC_FNMADD: return COP_FNMADD;
            default:
                case (f5)
                    F5_ADD:     return COP_ADD;
                    F5_SUB:     return COP_SUB;
                    F5_MUL:     return COP_MUL;
                    F5_CVT_S_W: return COP_CVT;
                    F5_DIV:     return COP_DIV;
                    F5_SQRT:    return COP_SQRT;
                    default:    return COP_NONE;
                endcase
        endcase
    endfunction

endpackage

// File: rtl/fpu_exec_unit_if.sv
// fpu_exec_unit_if: decode handshake, arithmetic-core link and writeback bundle
interface fpu_exec_unit_if;
    import fpu_pkg::*;

    logic        fpu_valid;
    logic [31:0] fp_inst;
    logic [31:0] fd1;
    logic [31:0] fd2;
    logic [31:0] fd3;
    logic [31:0] rs1_int;
    logic        flush;
    logic        fpu_busy;
    logic [31:0] ex_fp_inst;
    logic        core_start;
    core_op_e    core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_c;
    logic [2:0]  core_rm;
    logic        core_done;
    logic [31:0] core_result;
    logic [31:0] wb_fp_inst;
    logic [31:0] wb_fp_wdata;
    logic        wb_fp_regwen;

    modport master (
        output fpu_valid, fp_inst, fd1, fd2, fd3, rs1_int, flush, core_done, core_result,
        input  fpu_busy, ex_fp_inst, core_start, core_op, core_a, core_b, core_c, core_rm,
               wb_fp_inst, wb_fp_wdata, wb_fp_regwen
    );

    modport slave (
        input  fpu_valid, fp_inst, fd1, fd2, fd3, rs1_int, flush, core_done, core_result,
        output fpu_busy, ex_fp_inst, core_start, core_op, core_a, core_b, core_c, core_rm,
               wb_fp_inst, wb_fp_wdata, wb_fp_regwen
    );

endinterface

// File: rtl/fpu_simple_ops.sv
// fpu_simple_ops: single-cycle sign-inject, min/max and integer-to-FP move datapath
module fpu_simple_ops
    import fpu_pkg::*;
(
    input  logic [4:0]  funct5,
    input  logic [1:0]  funct3_lo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] rs1_int,
    output logic [31:0] result
);

    logic        a_nan;
    logic        b_nan;
    logic        a_lt_b;
    logic        sgn;
    logic [31:0] minmax;

    // Sign-magnitude ordering puts -0.0 below +0.0; a lone NaN yields the other operand
    always_comb begin
        a_nan  = &a[30:23] && |a[22:0];
        b_nan  = &b[30:23] && |b[22:0];
        a_lt_b = (a[31] != b[31]) ? a[31] : (a[31] ? a[30:0] > b[30:0] : a[30:0] < b[30:0]);
        minmax = (a_nan && b_nan) ? CANON_NAN :
                 a_nan ? b :
                 b_nan ? a :
                 (a_lt_b ^ funct3_lo[0]) ? a : b;
        sgn    = funct3_lo[1] ? a[31] ^ b[31] : funct3_lo[0] ? ~b[31] : b[31];
        result = funct5 == F5_MINMAX ? minmax :
                 funct5 == F5_MV_W_X ? rs1_int : {sgn, a[30:0]};
    end

endmodule

// File: rtl/fpu_exec_unit.sv
// fpu_exec_unit: EX-stage FP issue/sequencing unit driving pipelined and iterative cores
module fpu_exec_unit
    import fpu_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int CNT_W    = 4
) (
    input logic            clk,
    input logic            rst,
    fpu_exec_unit_if.slave bus
);

    state_e           state;
    state_e           state_nx;
    op_class_e        cls;
    logic             accept;
    logic             is_cvt;
    logic             start_q;
    logic             bad_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      inst_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      c_q;
    logic [31:0]      rs1_q;
    logic [31:0]      res_q;
    logic [31:0]      simple_res;

    fpu_simple_ops u_simple (
        .funct5    (bus.fp_inst[31:27]),
        .funct3_lo (bus.fp_inst[13:12]),
        .a         (bus.fd1),
        .b         (bus.fd2),
        .rs1_int   (bus.rs1_int),
        .result    (simple_res)
    );

    // Accept decision and next state; DONE may accept a new op back-to-back
    always_comb begin
        cls      = op_class(bus.fp_inst[6:0], bus.fp_inst[31:27], bus.fp_inst[14:12]);
        accept   = bus.fpu_valid && !bus.flush && (state == S_IDLE || state == S_DONE);
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = !accept ? S_IDLE :
                                       cls == CLS_PIPE ? S_WAIT_PIPE :
                                       cls == CLS_ITER ? S_WAIT_ITER : S_DONE;
            S_WAIT_PIPE:    state_nx = cnt == CNT_W'(1) ? S_DONE : S_WAIT_PIPE;
            S_WAIT_ITER:    state_nx = bus.core_done ? S_DONE : S_WAIT_ITER;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Outputs are derived from the held instruction so they stay stable while the core works
    always_comb begin
        is_cvt           = inst_q[6:0] == OPC_OP_FP && inst_q[31:27] == F5_CVT_S_W;
        bus.fpu_busy     = state == S_WAIT_PIPE || state == S_WAIT_ITER;
        bus.ex_fp_inst   = state == S_IDLE ? NOP : inst_q;
        bus.core_start   = start_q;
        bus.core_op      = core_op_of(inst_q[6:0], inst_q[31:27]);
        bus.core_a       = is_cvt ? rs1_q : a_q;
        bus.core_b       = is_cvt ? {31'b0, inst_q[20]} : b_q;
        bus.core_c       = c_q;
        bus.core_rm      = inst_q[14:12];
        bus.wb_fp_regwen = state == S_DONE && !bad_q;
        bus.wb_fp_inst   = state == S_DONE ? inst_q : NOP;
        bus.wb_fp_wdata  = state == S_DONE ? res_q : '0;
    end

    // State, operand latch, latency countdown and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            bad_q   <= 1'b0;
            inst_q  <= NOP;
            res_q   <= '0;
        end else begin
            state   <= state_nx;
            start_q <= accept && (cls == CLS_PIPE || cls == CLS_ITER);
            if (accept) begin
                inst_q <= bus.fp_inst;
                a_q    <= bus.fd1;
                b_q    <= bus.fd2;
                c_q    <= bus.fd3;
                rs1_q  <= bus.rs1_int;
                res_q  <= simple_res;
                bad_q  <= cls == CLS_BAD;
                cnt    <= cls == CLS_PIPE ? CNT_W'(PIPE_LAT) : '0;
            end else if (state == S_WAIT_PIPE) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    res_q <= bus.core_result;
            end else if (state == S_WAIT_ITER && bus.core_done) begin
                res_q <= bus.core_result;
            end
        end
    end

endmodule

// File: tb/tb_fpu_exec_unit.sv
// tb_fpu_exec_unit: directed self-checking bench for the FP execute unit
module tb_fpu_exec_unit;

    localparam logic [31:0] NOP_I = 32'h0000_0013;
    localparam logic [6:0]  OPFP  = 7'b1010011;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fpu_exec_unit_if bus ();

    fpu_exec_unit #(.PIPE_LAT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] f5, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] opc);
        return {f5, 2'b00, rs2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.fpu_valid = 1'b1;
        bus.fp_inst   = inst;
        bus.fd1       = a;
        bus.fd2       = b;
        bus.fd3       = c;
    endtask

    task automatic run_simple(input string tag, input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        offer(inst, a, b, 32'h0);
        @(negedge clk);
        chk1({tag, " busy_t"}, bus.fpu_busy, 1'b0);
        tick;
        bus.fpu_valid = 1'b0;
        @(negedge clk);
        chk1({tag, " regwen"}, bus.wb_fp_regwen, 1'b1);
        chk({tag, " wdata"}, bus.wb_fp_wdata, exp);
        chk({tag, " wb_inst"}, bus.wb_fp_inst, inst);
        chk1({tag, " busy_t1"}, bus.fpu_busy, 1'b0);
        tick;
    endtask

    task automatic run_pipe(input string tag, input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [3:0] eop, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] res);
        offer(inst, a, b, c);
        tick;
        bus.fpu_valid   = 1'b0;
        bus.core_result = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1({tag, " start"}, bus.core_start, 1'b1);
        chk1({tag, " busy1"}, bus.fpu_busy, 1'b1);
        chk({tag, " op"}, {28'b0, bus.core_op}, {28'b0, eop});
        chk({tag, " core_a"}, bus.core_a, ea);
        chk({tag, " core_b"}, bus.core_b, eb);
        chk({tag, " core_c"}, bus.core_c, c);
        chk({tag, " rm"}, {29'b0, bus.core_rm}, {29'b0, inst[14:12]});
        chk({tag, " ex1"}, bus.ex_fp_inst, inst);
        for (int i = 2; i <= 4; i++) begin
            tick;
            if (i == 4) bus.core_result = res;
            @(negedge clk);
            chk1({tag, " start_low"}, bus.core_start, 1'b0);
            chk1({tag, " busy_mid"}, bus.fpu_busy, 1'b1);
            chk1({tag, " regwen_mid"}, bus.wb_fp_regwen, 1'b0);
        end
        tick;
        bus.core_result = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1({tag, " regwen"}, bus.wb_fp_regwen, 1'b1);
        chk({tag, " wdata"}, bus.wb_fp_wdata, res);
        chk1({tag, " busy_done"}, bus.fpu_busy, 1'b0);
        chk({tag, " ex_done"}, bus.ex_fp_inst, inst);
        tick;
    endtask

    initial begin
        logic [31:0] fdiv_i;
        logic [31:0] fmax_i;
        logic [31:0] fadd_i;
        logic [31:0] bad_i;
        fdiv_i = enc(5'b00011, 5'd2, 3'b000, OPFP);
        fmax_i = enc(5'b00101, 5'd2, 3'b001, OPFP);
        fadd_i = enc(5'b00000, 5'd2, 3'b001, OPFP);
        bad_i  = enc(5'b10100, 5'd2, 3'b010, OPFP);

        rst             = 1'b0;
        bus.fpu_valid   = 1'b0;
        bus.fp_inst     = NOP_I;
        bus.fd1         = '0;
        bus.fd2         = '0;
        bus.fd3         = '0;
        bus.rs1_int     = '0;
        bus.flush       = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        tick;
        tick;
        @(negedge clk);
        chk1("rst busy", bus.fpu_busy, 1'b0);
        chk1("rst start", bus.core_start, 1'b0);
        chk1("rst regwen", bus.wb_fp_regwen, 1'b0);
        chk("rst wdata", bus.wb_fp_wdata, 32'h0);
        chk("rst ex", bus.ex_fp_inst, NOP_I);
        chk("rst wb_inst", bus.wb_fp_inst, NOP_I);
        rst = 1'b1;
        tick;

        run_simple("fsgnjn", enc(5'b00100, 5'd2, 3'b001, OPFP), 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000);
        run_simple("fsgnjx", enc(5'b00100, 5'd2, 3'b010, OPFP), 32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000);
        run_simple("fsgnj_nan", enc(5'b00100, 5'd2, 3'b000, OPFP), 32'h7FC0_0001, 32'h8000_0000, 32'hFFC0_0001);
        run_simple("fmax_nan", fmax_i, 32'h7FC0_0000, 32'hC000_0000, 32'hC000_0000);
        run_simple("fmin_zero", enc(5'b00101, 5'd2, 3'b000, OPFP), 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
        run_simple("fmin_zero_rev", enc(5'b00101, 5'd2, 3'b000, OPFP), 32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
        run_simple("fmax_both_nan", fmax_i, 32'h7F80_0001, 32'hFFC0_0000, 32'h7FC0_0000);
        run_simple("fmax_pos", fmax_i, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
        run_simple("fmin_neg", enc(5'b00101, 5'd2, 3'b000, OPFP), 32'hBF80_0000, 32'hC000_0000, 32'hC000_0000);
        bus.rs1_int = 32'h1234_5678;
        run_simple("fmv_w_x", enc(5'b11110, 5'd0, 3'b000, OPFP), 32'h0, 32'h0, 32'h1234_5678);

        run_pipe("fadd", fadd_i, 32'h3F80_0000, 32'h4000_0000, 32'h0, 4'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        run_pipe("fmadd", {5'd4, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1000011}, 32'h4000_0000, 32'h4040_0000,
                 32'h3F80_0000, 4'd3, 32'h4000_0000, 32'h4040_0000, 32'h40E0_0000);
        bus.rs1_int = 32'd5;
        run_pipe("fcvt_wu", enc(5'b11010, 5'd1, 3'b000, OPFP), 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0, 4'd7,
                 32'd5, 32'd1, 32'h40A0_0000);

        offer(fdiv_i, 32'h40C0_0000, 32'h4000_0000, 32'h0);
        @(negedge clk);
        chk1("fdiv busy_t", bus.fpu_busy, 1'b0);
        tick;
        bus.fpu_valid = 1'b0;
        @(negedge clk);
        chk1("fdiv start", bus.core_start, 1'b1);
        chk1("fdiv busy1", bus.fpu_busy, 1'b1);
        chk("fdiv op", {28'b0, bus.core_op}, 32'd8);
        tick;
        @(negedge clk);
        chk1("fdiv start_low", bus.core_start, 1'b0);
        tick;
        offer(fmax_i, 32'h7FC0_0000, 32'hC000_0000, 32'h0);
        for (int i = 3; i <= 8; i++) begin
            @(negedge clk);
            chk1("fdiv busy_wait", bus.fpu_busy, 1'b1);
            chk("fdiv ex_wait", bus.ex_fp_inst, fdiv_i);
            chk1("fdiv regwen_wait", bus.wb_fp_regwen, 1'b0);
            tick;
        end
        bus.core_done   = 1'b1;
        bus.core_result = 32'h4040_0000;
        @(negedge clk);
        chk1("fdiv busy_done_cycle", bus.fpu_busy, 1'b1);
        tick;
        bus.core_done   = 1'b0;
        bus.core_result = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("fdiv regwen", bus.wb_fp_regwen, 1'b1);
        chk("fdiv wdata", bus.wb_fp_wdata, 32'h4040_0000);
        chk("fdiv wb_inst", bus.wb_fp_inst, fdiv_i);
        chk1("fdiv busy_off", bus.fpu_busy, 1'b0);
        chk("fdiv ex_done", bus.ex_fp_inst, fdiv_i);
        tick;
        bus.fpu_valid = 1'b0;
        @(negedge clk);
        chk1("b2b regwen", bus.wb_fp_regwen, 1'b1);
        chk("b2b wb_inst", bus.wb_fp_inst, fmax_i);
        chk("b2b wdata", bus.wb_fp_wdata, 32'hC000_0000);
        tick;

        offer(fadd_i, 32'h3F80_0000, 32'h4000_0000, 32'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        chk1("flush busy", bus.fpu_busy, 1'b0);
        tick;
        bus.fpu_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk1("flush start", bus.core_start, 1'b0);
        chk("flush ex", bus.ex_fp_inst, NOP_I);
        chk1("flush regwen", bus.wb_fp_regwen, 1'b0);
        tick;

        offer(enc(5'b01011, 5'd0, 3'b000, OPFP), 32'h4080_0000, 32'h0, 32'h0);
        tick;
        bus.fpu_valid = 1'b0;
        @(negedge clk);
        chk1("fsqrt start", bus.core_start, 1'b1);
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst busy", bus.fpu_busy, 1'b0);
        chk1("mid_rst start", bus.core_start, 1'b0);
        chk("mid_rst ex", bus.ex_fp_inst, NOP_I);
        chk("mid_rst wb_inst", bus.wb_fp_inst, NOP_I);
        chk1("mid_rst regwen", bus.wb_fp_regwen, 1'b0);
        chk("mid_rst wdata", bus.wb_fp_wdata, 32'h0);
        bus.core_done   = 1'b1;
        bus.core_result = 32'h4000_0000;
        tick;
        @(negedge clk);
        chk1("late_done regwen", bus.wb_fp_regwen, 1'b0);
        chk1("late_done busy", bus.fpu_busy, 1'b0);
        chk("late_done ex", bus.ex_fp_inst, NOP_I);
        bus.core_done = 1'b0;
        tick;

        offer(bad_i, 32'h3F80_0000, 32'h3F80_0000, 32'h0);
        tick;
        bus.fpu_valid = 1'b0;
        @(negedge clk);
        chk1("bad regwen", bus.wb_fp_regwen, 1'b0);
        chk1("bad busy", bus.fpu_busy, 1'b0);
        chk("bad ex", bus.ex_fp_inst, bad_i);
        tick;
        @(negedge clk);
        chk("bad idle ex", bus.ex_fp_inst, NOP_I);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
